// File: rtl/ft60x_pkg.sv
// rtl/ft60x_pkg.sv - shared state encoding, grant and stats constants for the FT60x bus arbiter
package ft60x_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX_OE   = 3'd1,
        ST_RX_DATA = 3'd2,
        ST_TX_DATA = 3'd3,
        ST_TURN    = 3'd4
    } arb_state_t;

    localparam logic GRANT_RX = 1'b0;
    localparam logic GRANT_TX = 1'b1;

    localparam int STAT_WORD_W  = 32;
    localparam int STAT_BURST_W = 16;

endpackage

// File: rtl/ft60x_arb_stats.sv
// rtl/ft60x_arb_stats.sv - saturating word/burst counters, built only with FT60X_ARB_STATS_EN
module ft60x_arb_stats
    import ft60x_pkg::*;
(
    input  logic                    usb_clk,
    input  logic                    usb_rstn,
    input  logic                    rx_inc,
    input  logic                    tx_inc,
    input  logic                    burst_inc,
    output logic [STAT_WORD_W-1:0]  rx_words,
    output logic [STAT_WORD_W-1:0]  tx_words,
    output logic [STAT_BURST_W-1:0] bursts
);

    localparam logic [STAT_WORD_W-1:0]  WORD_MAX  = '1;
    localparam logic [STAT_WORD_W-1:0]  WORD_ONE  = 1;
    localparam logic [STAT_BURST_W-1:0] BURST_MAX = '1;
    localparam logic [STAT_BURST_W-1:0] BURST_ONE = 1;

    always_ff @(posedge usb_clk or negedge usb_rstn) begin
        if (!usb_rstn) begin
            rx_words <= '0;
            tx_words <= '0;
            bursts   <= '0;
        end else begin
            if (rx_inc && rx_words != WORD_MAX)
                rx_words <= rx_words + WORD_ONE;
            if (tx_inc && tx_words != WORD_MAX)
                tx_words <= tx_words + WORD_ONE;
            if (burst_inc && bursts != BURST_MAX)
                bursts <= bursts + BURST_ONE;
        end
    end

endmodule

// File: rtl/ft60x_bus_arbiter.sv
// rtl/ft60x_bus_arbiter.sv - FT60x 245-sync FIFO bus arbiter/sequencer; optional stats via FT60X_ARB_STATS_EN
module ft60x_bus_arbiter
    import ft60x_pkg::*;
#(
    parameter int MAX_BURST   = 256,
    parameter int TURN_CYCLES = 1
) (
    input  logic        usb_clk,
    input  logic        usb_rstn,
    input  logic        usb_txe_n,
    input  logic        usb_rxf_n,
    output logic        usb_wr_n,
    output logic        usb_rd_n,
    output logic        usb_oe_n,
    output logic        usb_data_t,
    input  logic        rx_afull,
    output logic        rx_wr_en,
    input  logic        tx_rd_valid,
    input  logic        tx_last,
    output logic        tx_rd_en,
    output logic [2:0]  arb_state
`ifdef FT60X_ARB_STATS_EN
    ,
    output logic [STAT_WORD_W-1:0]  stat_rx_words,
    output logic [STAT_WORD_W-1:0]  stat_tx_words,
    output logic [STAT_BURST_W-1:0] stat_bursts
`endif
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);
    localparam logic [3:0] TURN_ONE  = 4'd1;

    arb_state_t       state;
    logic             last_grant;
    logic [CNT_W-1:0] burst_cnt;
    logic [3:0]       turn_cnt;

    logic rx_req;
    logic tx_req;
    logic burst_full;
    logic rx_done;
    logic tx_done;

    assign rx_req = ~usb_rxf_n & ~rx_afull;
    assign tx_req = ~usb_txe_n & tx_rd_valid;

    // Strobes follow the pins combinationally so a word is never popped or captured
    // in a cycle the chip is not ready; everything else decodes the state register.
    assign rx_wr_en   = (state == ST_RX_DATA) & ~usb_rxf_n;
    assign tx_rd_en   = (state == ST_TX_DATA) & tx_rd_valid & ~usb_txe_n;
    assign usb_wr_n   = ~tx_rd_en;
    assign usb_rd_n   = (state != ST_RX_DATA);
    assign usb_oe_n   = ~((state == ST_RX_OE) | (state == ST_RX_DATA));
    assign usb_data_t = (state != ST_TX_DATA);
    assign arb_state  = state;

    assign burst_full = (burst_cnt == CNT_LAST);
    assign rx_done    = usb_rxf_n | rx_afull | (rx_wr_en & burst_full);
    assign tx_done    = usb_txe_n | ~tx_rd_valid | (tx_rd_en & (tx_last | burst_full));

    always_ff @(posedge usb_clk or negedge usb_rstn) begin
        if (!usb_rstn) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_TX;
            burst_cnt  <= '0;
            turn_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_req && (!tx_req || last_grant == GRANT_TX)) begin
                        state      <= ST_RX_OE;
                        last_grant <= GRANT_RX;
                    end else if (tx_req) begin
                        state      <= ST_TX_DATA;
                        last_grant <= GRANT_TX;
                    end
                end
                ST_RX_OE: state <= ST_RX_DATA;
                ST_RX_DATA: begin
                    if (rx_done) begin
                        state     <= ST_TURN;
                        burst_cnt <= '0;
                        turn_cnt  <= TURN_LOAD;
                    end else if (rx_wr_en) begin
                        burst_cnt <= burst_cnt + CNT_ONE;
                    end
                end
                ST_TX_DATA: begin
                    if (tx_done) begin
                        state     <= ST_TURN;
                        burst_cnt <= '0;
                        turn_cnt  <= TURN_LOAD;
                    end else if (tx_rd_en) begin
                        burst_cnt <= burst_cnt + CNT_ONE;
                    end
                end
                ST_TURN: begin
                    if (turn_cnt == 4'd0)
                        state <= ST_IDLE;
                    else
                        turn_cnt <= turn_cnt - TURN_ONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FT60X_ARB_STATS_EN
    logic turn_entry;

    assign turn_entry = ((state == ST_RX_DATA) & rx_done) | ((state == ST_TX_DATA) & tx_done);

    ft60x_arb_stats u_stats (
        .usb_clk   (usb_clk),
        .usb_rstn  (usb_rstn),
        .rx_inc    (rx_wr_en),
        .tx_inc    (tx_rd_en),
        .burst_inc (turn_entry),
        .rx_words  (stat_rx_words),
        .tx_words  (stat_tx_words),
        .bursts    (stat_bursts)
    );
`endif

endmodule

// File: tb/tb_ft60x_bus_arbiter.sv
// tb/tb_ft60x_bus_arbiter.sv - directed self-checking bench for ft60x_bus_arbiter (FT60X_ARB_STATS_EN aware)
module tb_ft60x_bus_arbiter;

    logic clk;
    logic rstn;

    logic rxf_n, txe_n, rx_afull, tx_valid, tx_last;
    logic wr_n, rd_n, oe_n, data_t, rx_wr_en, tx_rd_en;
    logic [2:0] state;

    logic rxf_n_b, txe_n_b, rx_afull_b, tx_valid_b, tx_last_b;
    logic wr_n_b, rd_n_b, oe_n_b, data_t_b, rx_wr_en_b, tx_rd_en_b;
    logic [2:0] state_b;

`ifdef FT60X_ARB_STATS_EN
    logic [31:0] stat_rx, stat_tx, stat_rx_b, stat_tx_b;
    logic [15:0] stat_bu, stat_bu_b;
`endif

    int checks = 0;
    int failures = 0;

    ft60x_bus_arbiter dut (
        .usb_clk     (clk),
        .usb_rstn    (rstn),
        .usb_txe_n   (txe_n),
        .usb_rxf_n   (rxf_n),
        .usb_wr_n    (wr_n),
        .usb_rd_n    (rd_n),
        .usb_oe_n    (oe_n),
        .usb_data_t  (data_t),
        .rx_afull    (rx_afull),
        .rx_wr_en    (rx_wr_en),
        .tx_rd_valid (tx_valid),
        .tx_last     (tx_last),
        .tx_rd_en    (tx_rd_en),
        .arb_state   (state)
`ifdef FT60X_ARB_STATS_EN
        ,
        .stat_rx_words (stat_rx),
        .stat_tx_words (stat_tx),
        .stat_bursts   (stat_bu)
`endif
    );

    ft60x_bus_arbiter #(.MAX_BURST(8), .TURN_CYCLES(2)) dut8 (
        .usb_clk     (clk),
        .usb_rstn    (rstn),
        .usb_txe_n   (txe_n_b),
        .usb_rxf_n   (rxf_n_b),
        .usb_wr_n    (wr_n_b),
        .usb_rd_n    (rd_n_b),
        .usb_oe_n    (oe_n_b),
        .usb_data_t  (data_t_b),
        .rx_afull    (rx_afull_b),
        .rx_wr_en    (rx_wr_en_b),
        .tx_rd_valid (tx_valid_b),
        .tx_last     (tx_last_b),
        .tx_rd_en    (tx_rd_en_b),
        .arb_state   (state_b)
`ifdef FT60X_ARB_STATS_EN
        ,
        .stat_rx_words (stat_rx_b),
        .stat_tx_words (stat_tx_b),
        .stat_bursts   (stat_bu_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic idle_a();
        rxf_n = 1'b1; txe_n = 1'b1; rx_afull = 1'b0; tx_valid = 1'b0; tx_last = 1'b0;
    endtask

    // rx_afull rises after three words, alone or together with usb_rxf_n.
    task automatic afull_case(input bit with_rxf, input int exp_pulses, input int exp_wr);
        int pulses = 0;
        int turns = 0;
        int wr_at_rise = -1;
        int prev = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            rx_afull = (pulses >= 3);
            rxf_n    = with_rxf ? (pulses >= 3) : 1'b0;
            @(negedge clk);
            if (rx_afull && wr_at_rise < 0) wr_at_rise = int'(rx_wr_en);
            if (rx_wr_en) pulses++;
            if (state == 3'd4 && prev != 4) turns++;
            prev = int'(state);
        end
        check($sformatf("afull%0d_pulses", with_rxf), pulses, exp_pulses);
        check($sformatf("afull%0d_wr_at_rise", with_rxf), wr_at_rise, exp_wr);
        check($sformatf("afull%0d_turns", with_rxf), turns, 1);
        @(posedge clk); #1;
        idle_a();
        repeat (3) @(posedge clk);
    endtask

    initial begin
        rstn = 1'b0;
        idle_a();
        rxf_n_b = 1'b1; txe_n_b = 1'b1; rx_afull_b = 1'b0; tx_valid_b = 1'b0; tx_last_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", state, 0);
        check("rst_wr_n", wr_n, 1);
        check("rst_rd_n", rd_n, 1);
        check("rst_oe_n", oe_n, 1);
        check("rst_data_t", data_t, 1);
        check("rst_rx_wr_en", rx_wr_en, 0);
        check("rst_tx_rd_en", tx_rd_en, 0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Both directions requesting continuously, MAX_BURST = 8, TURN_CYCLES = 2
        begin
            int kind[4];
            int len[4];
            int seen = 0, cur_words = 0, cur_kind = 0, prev = 0, turn_run = 0, first_turn = -1, bad_dt = 0;
            for (int i = 0; i < 4; i++) begin kind[i] = 0; len[i] = 0; end
            @(posedge clk); #1;
            rxf_n_b = 1'b0; txe_n_b = 1'b0; tx_valid_b = 1'b1;
            for (int c = 0; c < 300 && seen < 4; c++) begin
                @(negedge clk);
                if (rx_wr_en_b) begin cur_words++; cur_kind = 1; end
                if (tx_rd_en_b) begin cur_words++; cur_kind = 2; end
                if (data_t_b !== (state_b != 3'd3)) bad_dt++;
                if (state_b == 3'd4) turn_run++;
                if (state_b == 3'd4 && prev != 4) begin
                    kind[seen] = cur_kind; len[seen] = cur_words; seen++; cur_words = 0;
                end
                if (state_b != 3'd4 && prev == 4 && first_turn < 0) first_turn = turn_run;
                prev = int'(state_b);
            end
            check("rr_bursts", seen, 4);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("rr_kind%0d", i), kind[i], (i % 2 == 0) ? 1 : 2);
                check($sformatf("rr_len%0d", i), len[i], 8);
            end
            check("rr_turn_len", first_turn, 2);
            check("rr_data_t", bad_dt, 0);
`ifdef FT60X_ARB_STATS_EN
            check("rr_stat_rx", stat_rx_b, 16);
            check("rr_stat_tx", stat_tx_b, 16);
            check("rr_stat_bursts", stat_bu_b, 4);
`endif
            @(posedge clk); #1;
            rxf_n_b = 1'b1; txe_n_b = 1'b1; tx_valid_b = 1'b0;
        end

        // 20-word RX burst
        begin
            int pulses = 0, oe_cyc = 0, rd_low = 0, oe_low = 0, turn_cyc = 0, first_wr = -1, bad = 0, end_state = -1;
            bit seen_turn = 0;
            for (int c = 0; c < 60; c++) begin
                @(posedge clk); #1;
                rxf_n = (pulses < 20) ? 1'b0 : 1'b1;
                @(negedge clk);
                if (rx_wr_en) begin pulses++; if (first_wr < 0) first_wr = c; end
                if (state == 3'd1) oe_cyc++;
                if (!rd_n) rd_low++;
                if (!oe_n) oe_low++;
                if (data_t !== 1'b1) bad++;
                if (state == 3'd4) begin turn_cyc++; seen_turn = 1; end
                else if (seen_turn) begin end_state = int'(state); break; end
            end
            check("rx_first_latency", first_wr, 2);
            check("rx_pulses", pulses, 20);
            check("rx_oe_cycles", oe_cyc, 1);
            check("rx_rd_low", rd_low, 21);
            check("rx_oe_low", oe_low, 22);
            check("rx_turn_cycles", turn_cyc, 1);
            check("rx_data_t", bad, 0);
            check("rx_end_idle", end_state, 0);
            @(posedge clk); #1; idle_a();
        end

        // 21-word TX packet
        begin
            int pops = 0, first_pop = -1, wr_low = 0, wr_bad = 0, dt_low = 0, turn_at = -1, end_state = -1;
            bit seen_turn = 0;
            for (int c = 0; c < 80; c++) begin
                @(posedge clk); #1;
                txe_n = 1'b0; tx_valid = (pops < 21); tx_last = (pops == 20);
                @(negedge clk);
                if (tx_rd_en) begin pops++; if (first_pop < 0) first_pop = c; end
                if (!wr_n) wr_low++;
                if (wr_n !== !tx_rd_en) wr_bad++;
                if (!data_t) dt_low++;
                if (state == 3'd4) begin if (turn_at < 0) turn_at = c; seen_turn = 1; end
                else if (seen_turn) begin end_state = int'(state); break; end
            end
            check("tx_pops", pops, 21);
            check("tx_first_latency", first_pop, 1);
            check("tx_wr_low", wr_low, 21);
            check("tx_wr_match", wr_bad, 0);
            check("tx_data_t_low", dt_low, 21);
            check("tx_turn_at", turn_at, 22);
            check("tx_end_idle", end_state, 0);
            @(posedge clk); #1; idle_a();
        end

`ifdef FT60X_ARB_STATS_EN
        check("stat_rx_words", stat_rx, 20);
        check("stat_tx_words", stat_tx, 21);
        check("stat_bursts", stat_bu, 2);
`endif

        // txe_n rises after word 5, burst resumes with word 5 (0-based) on re-grant
        begin
            int pops = 0, hold = 0, pop_hi = 0, turns = 0, idx_turn1 = -1, resume_idx = -1, wr_bad = 0, prev = 0, st_rise = -1;
            for (int c = 0; c < 80; c++) begin
                @(posedge clk); #1;
                txe_n = (pops == 5 && hold < 3);
                if (txe_n) hold++;
                tx_valid = (pops < 10); tx_last = (pops == 9);
                @(negedge clk);
                if (txe_n && hold == 1) st_rise = int'(state);
                if (tx_rd_en) begin
                    if (txe_n) pop_hi++;
                    if (hold > 0 && resume_idx < 0) resume_idx = pops;
                    pops++;
                end
                if (wr_n !== !tx_rd_en) wr_bad++;
                if (state == 3'd4 && prev != 4) begin turns++; if (idx_turn1 < 0) idx_turn1 = pops; end
                if (state == 3'd0 && prev == 4 && turns == 2) break;
                prev = int'(state);
            end
            check("txe_state_at_rise", st_rise, 3);
            check("txe_pop_while_full", pop_hi, 0);
            check("txe_words_before_turn", idx_turn1, 5);
            check("txe_resume_word", resume_idx, 5);
            check("txe_total_pops", pops, 10);
            check("txe_turns", turns, 2);
            check("txe_wr_match", wr_bad, 0);
            @(posedge clk); #1; idle_a();
        end

        afull_case(1'b0, 4, 1);
        afull_case(1'b1, 3, 0);

        // Asynchronous reset in the middle of RX_DATA
        begin
            int st = -1;
            @(posedge clk); #1;
            rxf_n = 1'b0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (state == 3'd2) begin st = 2; break; end
            end
            check("arst_reached_rx_data", st, 2);
            @(posedge clk); #3;
            rstn = 1'b0;
            #1;
            check("arst_rd_n", rd_n, 1);
            check("arst_oe_n", oe_n, 1);
            check("arst_data_t", data_t, 1);
            check("arst_state", state, 0);
            check("arst_rx_wr_en", rx_wr_en, 0);
            @(posedge clk); #1;
            txe_n = 1'b0; tx_valid = 1'b1; tx_last = 1'b0;
            rstn = 1'b1;
            @(negedge clk);
            check("arst_idle_after_release", state, 0);
            @(negedge clk);
            check("arst_rx_wins_tie", state, 1);
            @(posedge clk); #1; idle_a();
            repeat (10) @(posedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ft60x_bus_arbiter.md
Name: ft60x_bus_arbiter

Overview:
- Arbitrates and sequences the shared FT60x 245-synchronous FIFO bus between the receive path (chip→FPGA) and the transmit path (FPGA→chip).
- Sits in the usb_clk domain inside the FTDI top level, between the pins and the rx/tx CDC buffers.
- Generates usb_oe_n, usb_rd_n, usb_wr_n and the data/BE tristate control.
- Issues write strobes to the rx buffer and pop strobes to the tx buffer; it carries no data itself.

Parameters:
- MAX_BURST, 256: maximum words per grant before a forced turnaround (range 2–65535).
- TURN_CYCLES, 1: idle cycles in the TURN state between bursts (range 1–15).

Ports:
- usb_clk  in  1  FT60x bus clock; the only clock.
- usb_rstn  in  1  asynchronous reset, active-low.
- usb_txe_n  in  1  chip tx FIFO has space; active-low.
- usb_rxf_n  in  1  chip rx FIFO has data; active-low.
- usb_wr_n  out  1  chip write strobe; active-low.
- usb_rd_n  out  1  chip read strobe; active-low.
- usb_oe_n  out  1  chip data output enable; active-low.
- usb_data_t  out  1  tristate control for data and BE; 1 = input, 0 = FPGA drives.
- rx_afull  in  1  rx buffer prog_full.
- rx_wr_en  out  1  capture usb_data_i/usb_be_i into the rx buffer this cycle.
- tx_rd_valid  in  1  FWFT tx buffer has a word on its output.
- tx_last  in  1  current tx word is the last word of its packet.
- tx_rd_en  out  1  pop the current tx word; it is on the bus this cycle.
- arb_state  out  3  current FSM state, for debug.

Behaviour:
- Reset state while usb_rstn is low:
  - FSM = IDLE.
  - usb_wr_n = usb_rd_n = usb_oe_n = 1; usb_data_t = 1.
  - rx_wr_en = tx_rd_en = 0.
  - burst counter = 0; last_grant = TX, so rx wins the first tie.
- Reset may assert in any state. Outputs return to their reset values asynchronously, and no partial strobe survives.
- Requests, evaluated in IDLE:
  - rx_req = ~usb_rxf_n & ~rx_afull.
  - tx_req = ~usb_txe_n & tx_rd_valid.
- Arbitration:
  - Only one request set → grant it.
  - Both set → grant the path opposite to last_grant (round-robin).
  - Neither set → stay in IDLE.
  - last_grant updates on entry to RX_OE or TX_DATA.
- States and encodings (arb_state):
  - IDLE (0): all strobes high; data_t = 1.
  - RX_OE (1): oe_n = 0; rd_n = 1; data_t = 1. Lasts exactly 1 cycle, then RX_DATA.
  - RX_DATA (2): oe_n = 0; rd_n = 0; data_t = 1.
    - rx_wr_en = ~usb_rxf_n, combinational from the sampled pin.
    - Each rx_wr_en increments the burst counter.
  - TX_DATA (3): data_t = 0.
    - tx_rd_en = tx_rd_valid & ~usb_txe_n; usb_wr_n = ~tx_rd_en.
    - Each tx_rd_en increments the burst counter.
  - TURN (4): all strobes high; data_t = 1. Holds TURN_CYCLES cycles, then IDLE. The burst counter clears on entry.
- RX_DATA → TURN at the clock edge where any of these holds:
  - usb_rxf_n = 1;
  - rx_afull = 1;
  - a transfer brings the burst counter to MAX_BURST.
- TX_DATA → TURN at the clock edge where any of these holds:
  - usb_txe_n = 1;
  - tx_rd_valid = 0;
  - tx_rd_en & tx_last (packet end: forces a turnaround so the chip can flush the short packet);
  - a transfer brings the burst counter to MAX_BURST.
- Boundary conditions:
  - Burst counter width is clog2(MAX_BURST+1) and it never wraps.
  - If usb_rxf_n rises in the same cycle rx_afull rises, exactly one TURN entry occurs, and rx_wr_en follows usb_rxf_n in that cycle.
  - usb_data_t = 0 only in TX_DATA. TURN is the only path between the two bus directions, so the bus is never driven from both ends.
  - rx_afull asserting mid-burst does not suppress rx_wr_en in the cycle it rises. The prog_full threshold provides the headroom.
- Latency:
  - Request in IDLE → first rx_wr_en after 2 cycles (IDLE→RX_OE→RX_DATA).
  - Request in IDLE → first tx_rd_en after 1 cycle.

Optional Feature:
- Macro: FT60X_ARB_STATS_EN.
- Defined: adds output ports stat_rx_words[31:0], stat_tx_words[31:0] and stat_bursts[15:0].
  - These count rx_wr_en pulses, tx_rd_en pulses and TURN entries.
  - All three saturate at their maximum and clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package ft60x_pkg holds:
  - the state encoding constants (IDLE..TURN);
  - the GRANT_RX / GRANT_TX constants;
  - the stats counter widths.
- Natural sub-module: ft60x_arb_stats, holding the saturating counters. It is instantiated only under FT60X_ARB_STATS_EN.

Test Plan:
1. rxf_n low for 20 cycles with rx_afull = 0 → RX_OE for 1 cycle, then 20 rx_wr_en pulses, then TURN for 1 cycle, then IDLE. usb_data_t stays 1 throughout.
2. tx_rd_valid high with tx_last on word 21 and txe_n = 0 → 21 tx_rd_en pulses; usb_wr_n is low in exactly those cycles; TURN follows the last word.
3. rxf_n and tx request both asserted continuously with MAX_BURST = 8 → bursts alternate RX, TX, RX, TX, each exactly 8 words, separated by TURN_CYCLES idle cycles.
4. txe_n rises after word 5 of a TX burst → tx_rd_en drops that cycle, FSM enters TURN, and no word is lost; on re-grant the burst resumes with the next word.
5. usb_rstn pulled low mid RX_DATA → usb_rd_n, usb_oe_n and usb_data_t go to 1 asynchronously; arb_state = 0; rx wins the next tie.
6. With FT60X_ARB_STATS_EN defined, run scenarios 1 and 2 → stat_rx_words = 20, stat_tx_words = 21, stat_bursts = 2.
